// File: rtl/posit_adder_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : posit_sched_pkg
//  Brief    : Shared types and constants for the posit adder scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package posit_sched_pkg;

   // Largest supported requester count; sizes the tag id field.
   localparam int R_MAX         = 16;
   // Default pipeline depth of the shared posit_adder.
   localparam int ADDER_LATENCY = 3;

   typedef logic [$clog2(R_MAX)-1:0] req_id_t;

   // One slot of the tag pipeline that follows an operation through the adder.
   typedef struct packed {
      logic    valid;
      req_id_t id;
   } sched_tag_t;

endpackage
`default_nettype wire

// File: rtl/posit_adder_sched_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick. Scans req from ptr upward,
//             wrapping modulo R, and returns the first hit as one-hot + index.
//             The rotating pointer itself lives in the parent.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import posit_sched_pkg::*;
#(
   parameter int R = 4
) (
   input  logic [R-1:0]         req,
   input  logic                 en,
   input  logic [$clog2(R)-1:0] ptr,
   output logic [R-1:0]         gnt,
   output logic [$clog2(R)-1:0] gnt_id
);

   localparam int IW  = $clog2(R);
   // One extra bit so ptr+k can exceed R before the wrap is applied.
   localparam int IW1 = IW + 1;

   logic [IW1-1:0] w_idx;
   logic           w_found;

   // Priority scan starting at ptr; the first pending request wins.
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < R; k++) begin
         w_idx = {1'b0, ptr} + IW1'(k);
         if (w_idx >= IW1'(R)) begin
            w_idx = w_idx - IW1'(R);
         end
         if (en && !w_found && req[w_idx[IW-1:0]]) begin
            gnt[w_idx[IW-1:0]] = 1'b1;
            gnt_id             = w_idx[IW-1:0];
            w_found            = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/posit_adder_sched.sv
`default_nettype none
// ============================================================================
//  Module   : posit_adder_sched
//  Brief    : Round-robin scheduler sharing one pipelined posit_adder among R
//             requesters. Issues at most one operand pair per cycle through
//             registered outputs, carries the owner id alongside the adder
//             pipeline and steers each returning result to its owner.
//  Options  : POSIT_ADDER_SCHED_TAG_CHECK_EN - enables the sticky tag_err
//             check of add_done against the tag pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module posit_adder_sched
   import posit_sched_pkg::*;
#(
   parameter int N       = 8,
   parameter int R       = 4,
   parameter int LATENCY = ADDER_LATENCY
) (
   input  logic           aclk,
   input  logic           areset,
   input  logic           issue_en,
   input  logic [R-1:0]   req_valid,
   output logic [R-1:0]   req_ready,
   input  logic [R*N-1:0] req_in1,
   input  logic [R*N-1:0] req_in2,
   output logic [N-1:0]   add_in1,
   output logic [N-1:0]   add_in2,
   output logic           add_start,
   input  logic [N-1:0]   add_result,
   input  logic           add_inf,
   input  logic           add_zero,
   input  logic           add_done,
   output logic [R-1:0]   res_valid,
   output logic [N-1:0]   res_data,
   output logic           res_inf,
   output logic           res_zero,
   output logic           tag_err
);

   localparam int IW = $clog2(R);

   logic [IW-1:0] r_ptr;
   logic [R-1:0]  w_gnt;
   logic [IW-1:0] w_gnt_id;
   logic          w_grant;
   logic          w_arb_en;
   logic [IW-1:0] w_ptr_nxt;

   logic          r_add_start;
   logic [N-1:0]  r_add_in1;
   logic [N-1:0]  r_add_in2;
   logic [IW-1:0] r_issue_id;

   sched_tag_t    r_tag [LATENCY];
   sched_tag_t    w_last;

   logic [N-1:0]  w_op1 [R];
   logic [N-1:0]  w_op2 [R];

   // Gating with areset keeps req_ready low for the whole reset window.
   assign w_arb_en = issue_en & ~areset;

   rr_arbiter #(
      .R (R)
   ) u_arb (
      .req    (req_valid),
      .en     (w_arb_en),
      .ptr    (r_ptr),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id)
   );

   assign req_ready = w_gnt;
   assign w_grant   = |w_gnt;
   assign w_ptr_nxt = (w_gnt_id == IW'(R - 1)) ? '0 : w_gnt_id + 1'b1;

   // Split the flattened operand buses into per-requester words.
   for (genvar g = 0; g < R; g++) begin : g_unpack
      assign w_op1[g] = req_in1[g*N +: N];
      assign w_op2[g] = req_in2[g*N +: N];
   end

   // Rotate the priority pointer past the winner on every grant.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         r_ptr <= w_ptr_nxt;
      end
   end

   // Register the winner's operands and the issue strobe towards the adder.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_add_start <= 1'b0;
         r_add_in1   <= '0;
         r_add_in2   <= '0;
         r_issue_id  <= '0;
      end else begin
         r_add_start <= w_grant;
         if (w_grant) begin
            r_add_in1  <= w_op1[w_gnt_id];
            r_add_in2  <= w_op2[w_gnt_id];
            r_issue_id <= w_gnt_id;
         end
      end
   end

   // Tag pipeline: stage 0 samples the issue strobe, last stage meets add_done.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int k = 0; k < LATENCY; k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         r_tag[0] <= '{valid: r_add_start, id: req_id_t'(r_issue_id)};
         for (int k = 1; k < LATENCY; k++) begin
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   assign w_last = r_tag[LATENCY-1];

   // Steer the completion strobe to the owner recorded in the last tag stage.
   always_comb begin
      res_valid = '0;
      for (int i = 0; i < R; i++) begin
         res_valid[i] = add_done & w_last.valid & (w_last.id == req_id_t'(i));
      end
   end

   assign res_data  = add_result;
   assign res_inf   = add_inf;
   assign res_zero  = add_zero;

   assign add_start = r_add_start;
   assign add_in1   = r_add_in1;
   assign add_in2   = r_add_in2;

`ifdef POSIT_ADDER_SCHED_TAG_CHECK_EN
   localparam int CW = $clog2(LATENCY + 1);

   logic [CW-1:0] r_mask_cnt;
   logic          r_tag_err;

   // Mask the check for LATENCY cycles after reset so stale adder strobes from
   // pre-reset operations are not flagged; afterwards any disagreement sticks.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_mask_cnt <= CW'(LATENCY);
         r_tag_err  <= 1'b0;
      end else begin
         if (r_mask_cnt != '0) begin
            r_mask_cnt <= r_mask_cnt - 1'b1;
         end else if (add_done != w_last.valid) begin
            r_tag_err <= 1'b1;
         end
      end
   end

   assign tag_err = r_tag_err;
`else
   assign tag_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_posit_adder_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_posit_adder_sched
//  Brief    : Self-checking bench for posit_adder_sched. A stand-in adder
//             (plain delay line, no reset) sits on the adder port; a queue
//             based reference model predicts grants and returned results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_posit_adder_sched;

   localparam int N   = 8;
   localparam int R   = 4;
   localparam int LAT = 3;

   logic           aclk      = 1'b0;
   logic           areset    = 1'b0;
   logic           issue_en  = 1'b0;
   logic [R-1:0]   req_valid = '0;
   logic [R*N-1:0] req_in1   = '0;
   logic [R*N-1:0] req_in2   = '0;
   logic [R-1:0]   req_ready;
   logic [N-1:0]   add_in1;
   logic [N-1:0]   add_in2;
   logic           add_start;
   logic [N-1:0]   add_result;
   logic           add_inf;
   logic           add_zero;
   logic           add_done;
   logic [R-1:0]   res_valid;
   logic [N-1:0]   res_data;
   logic           res_inf;
   logic           res_zero;
   logic           tag_err;
   logic           inj = 1'b0;

   always #5 aclk = ~aclk;

   posit_adder_sched #(
      .N       (N),
      .R       (R),
      .LATENCY (LAT)
   ) dut (
      .aclk       (aclk),
      .areset     (areset),
      .issue_en   (issue_en),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_in1    (req_in1),
      .req_in2    (req_in2),
      .add_in1    (add_in1),
      .add_in2    (add_in2),
      .add_start  (add_start),
      .add_result (add_result),
      .add_inf    (add_inf),
      .add_zero   (add_zero),
      .add_done   (add_done),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_inf    (res_inf),
      .res_zero   (res_zero),
      .tag_err    (tag_err)
   );

   // Stand-in adder: result = in1 + in2 (mod 2^N), LAT cycles, never reset.
   bit         pv [LAT] = '{default: 1'b0};
   bit [N-1:0] pa [LAT] = '{default: '0};
   bit [N-1:0] pb [LAT] = '{default: '0};

   always @(posedge aclk) begin
      pv[0] <= add_start;
      pa[0] <= add_in1;
      pb[0] <= add_in2;
      for (int k = 1; k < LAT; k++) begin
         pv[k] <= pv[k-1];
         pa[k] <= pa[k-1];
         pb[k] <= pb[k-1];
      end
   end

   assign add_result = pa[LAT-1] + pb[LAT-1];
   assign add_inf    = (add_result == 8'h80);
   assign add_zero   = (add_result == 8'h00);
   assign add_done   = pv[LAT-1] | inj;

   // Reference model state
   typedef struct {
      int         due;
      int         id;
      logic [N-1:0] data;
   } exp_t;

   exp_t         q[$];
   int           n_cmp   = 0;
   int           n_mis   = 0;
   int           cyc     = 0;
   int           ref_ptr = 0;
   logic         exp_start = 1'b0;
   logic [N-1:0] exp_in1   = '0;
   logic [N-1:0] exp_in2   = '0;
   logic         exp_err   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive at negedge, check 1ns later, then advance the model.
   task automatic step(input logic [R-1:0] v, input logic en,
                       input logic [R*N-1:0] op1, input logic [R*N-1:0] op2,
                       input logic injv);
      int           w;
      logic [R-1:0] exp_rdy;
      logic [R-1:0] exp_rv;
      logic [N-1:0] a;
      logic [N-1:0] b;
      exp_t         e;
      @(negedge aclk);
      req_valid = v;
      issue_en  = en;
      req_in1   = op1;
      req_in2   = op2;
      inj       = injv;
      #1;
      chk("add_start", add_start, exp_start);
      chk("add_in1", add_in1, exp_in1);
      chk("add_in2", add_in2, exp_in2);
      w = -1;
      if (en) begin
         for (int k = 0; k < R; k++) begin
            if (v[(ref_ptr + k) % R]) begin
               w = (ref_ptr + k) % R;
               break;
            end
         end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      exp_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         exp_rv[e.id] = 1'b1;
         chk("res_data", res_data, e.data);
         chk("res_inf", res_inf, e.data == 8'h80);
         chk("res_zero", res_zero, e.data == 8'h00);
      end
      chk("res_valid", res_valid, exp_rv);
      chk("tag_err", tag_err, exp_err);
      exp_start = (w >= 0);
      if (w >= 0) begin
         a       = op1[w*N +: N];
         b       = op2[w*N +: N];
         exp_in1 = a;
         exp_in2 = b;
         ref_ptr = (w + 1) % R;
         q.push_back('{due: cyc + 1 + LAT, id: w, data: a + b});
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step('0, 1'b1, $urandom, $urandom, 1'b0);
   endtask

   // Assert reset for ncyc cycles with requests pending, checking cleared outputs.
   task automatic do_reset(input int ncyc);
      @(negedge aclk);
      areset    = 1'b1;
      req_valid = '1;
      issue_en  = 1'b1;
      inj       = 1'b0;
      #1;
      chk("rst_add_start", add_start, 0);
      chk("rst_add_in1", add_in1, 0);
      chk("rst_add_in2", add_in2, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_tag_err", tag_err, 0);
      cyc++;
      repeat (ncyc - 1) begin
         @(negedge aclk);
         #1;
         chk("rst_res_valid", res_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         cyc++;
      end
      @(negedge aclk);
      areset    = 1'b0;
      req_valid = '0;
      issue_en  = 1'b0;
      cyc++;
      q.delete();
      ref_ptr   = 0;
      exp_start = 1'b0;
      exp_in1   = '0;
      exp_in2   = '0;
      exp_err   = 1'b0;
   endtask

   initial begin
      do_reset(3);
      idle(4);

      // Single requester: 0x40 + 0x40 in the stand-in adder gives 0x80 (inf flag)
      step(4'b0010, 1'b1, {4{8'h40}}, {4{8'h40}}, 1'b0);
      idle(6);

      // Zero-result boundary on requester 3
      step(4'b1000, 1'b1, {4{8'h10}}, {4{8'hF0}}, 1'b0);
      idle(6);

      // All requesters contend from ptr = 0
      do_reset(2);
      repeat (8) step('1, 1'b1, $urandom, $urandom, 1'b0);
      idle(6);

      // Pause with issue_en low while requests stay valid
      step('1, 1'b1, $urandom, $urandom, 1'b0);
      step('1, 1'b1, $urandom, $urandom, 1'b0);
      repeat (5) step('1, 1'b0, $urandom, $urandom, 1'b0);
      idle(6);

      // Randomized traffic
      repeat (400) step(R'($urandom), ($urandom_range(0, 3) != 0), $urandom, $urandom, 1'b0);
      idle(6);

      // Reset mid-flight: stale adder strobes must not reach res_valid
      step(4'b0001, 1'b1, $urandom, $urandom, 1'b0);
      step(4'b0100, 1'b1, $urandom, $urandom, 1'b0);
      do_reset(1);
      idle(8);
      step(4'b0100, 1'b1, $urandom, $urandom, 1'b0);
      idle(6);

      // Spurious add_done with nothing in flight
      step('0, 1'b0, $urandom, $urandom, 1'b1);
`ifdef POSIT_ADDER_SCHED_TAG_CHECK_EN
      exp_err = 1'b1;
`endif
      idle(5);
      do_reset(2);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
